// File: rtl/mem_boot_loader.sv
// Boot front-end: unpacks a framed byte stream into word writes on N_CH memories and
// holds the core in reset until the image is loaded plus N_RESET cycles.
//
// state | meaning
// HDR   | waiting for frame header {end, ch}
// LEN0  | segment length, low byte
// LEN1  | segment length, high byte
// ADR0  | segment base byte address, low byte
// ADR1  | segment base byte address, high byte; range check
// DATA  | payload bytes packed into words
// HOLD  | image complete, core-reset hold timer running
// DONE  | core released
// ERR   | image rejected, core held in reset until external reset
module mem_boot_loader #(
    parameter  int N_CH       = 2,
    parameter  int ADDR_W     = 10,
    parameter  int WORD_BYTES = 4,
    parameter  int N_RESET    = 10,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LANE_W     = $clog2(WORD_BYTES),
    localparam int DATA_W     = 8 * WORD_BYTES
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_s_valid,
    input  logic [7:0]            i_s_data,
    output logic                  o_s_ready,
    output logic                  o_mem_we,
    output logic [CH_W-1:0]       o_mem_ch,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [WORD_BYTES-1:0] o_mem_be,
    output logic                  o_core_reset,
    output logic                  o_boot_done,
    output logic                  o_boot_err,
    output logic [1:0]            o_err_code
);

    localparam int          CNT_W     = $clog2(N_RESET + 1);
    localparam logic [16:0] MEM_BYTES = 17'(2 ** ADDR_W);

    typedef enum logic [3:0] {
        S_HDR, S_LEN0, S_LEN1, S_ADR0, S_ADR1, S_DATA, S_HOLD, S_DONE, S_ERR
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CH_W-1:0]       r_ch, w_ch_nxt;
    logic [15:0]           r_len, w_len_nxt;
    logic [7:0]            r_base_lo, w_base_lo_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic [15:0]           r_remain, w_remain_nxt;
    logic [DATA_W-1:0]     r_buf, w_buf_nxt, w_buf_upd;
    logic [WORD_BYTES-1:0] r_be, w_be_nxt, w_be_upd;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

    logic                  w_we_nxt;
    logic [CH_W-1:0]       w_mem_ch_nxt;
    logic [ADDR_W-1:0]     w_mem_addr_nxt;
    logic [DATA_W-1:0]     w_wdata_nxt;
    logic [WORD_BYTES-1:0] w_mem_be_nxt;
    logic                  w_core_reset_nxt;
    logic                  w_boot_done_nxt;
    logic                  w_boot_err_nxt;
    logic [1:0]            w_err_code_nxt;
    logic                  w_s_ready_nxt;

    logic                  w_acc;
    logic [LANE_W-1:0]     w_lane;
    logic [15:0]           w_base;
    logic [16:0]           w_end;

    assign w_acc  = i_s_valid & o_s_ready;
    assign w_lane = r_addr[LANE_W-1:0];
    assign w_base = {i_s_data, r_base_lo};
    // 17-bit sum so a segment ending exactly at the top of memory is accepted
    assign w_end  = {1'b0, w_base} + {1'b0, r_len};

    always_comb begin
        w_state_nxt      = r_state;
        w_ch_nxt         = r_ch;
        w_len_nxt        = r_len;
        w_base_lo_nxt    = r_base_lo;
        w_addr_nxt       = r_addr;
        w_remain_nxt     = r_remain;
        w_buf_nxt        = r_buf;
        w_be_nxt         = r_be;
        w_cnt_nxt        = r_cnt;
        w_we_nxt         = 1'b0;
        w_mem_ch_nxt     = o_mem_ch;
        w_mem_addr_nxt   = o_mem_addr;
        w_wdata_nxt      = o_mem_wdata;
        w_mem_be_nxt     = o_mem_be;
        w_core_reset_nxt = o_core_reset;
        w_boot_done_nxt  = o_boot_done;
        w_boot_err_nxt   = o_boot_err;
        w_err_code_nxt   = o_err_code;

        w_buf_upd = r_buf;
        w_buf_upd[{w_lane, 3'b000} +: 8] = i_s_data;
        w_be_upd = r_be;
        w_be_upd[w_lane] = 1'b1;

        case (r_state)
            S_HDR: if (w_acc) begin
                if (i_s_data[7]) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CNT_W'(N_RESET);
                end else if (i_s_data[6:0] >= 7'(N_CH)) begin
                    w_state_nxt    = S_ERR;
                    w_boot_err_nxt = 1'b1;
                    w_err_code_nxt = 2'd1;
                end else begin
                    w_ch_nxt    = i_s_data[CH_W-1:0];
                    w_state_nxt = S_LEN0;
                end
            end
            S_LEN0: if (w_acc) begin
                w_len_nxt[7:0] = i_s_data;
                w_state_nxt    = S_LEN1;
            end
            S_LEN1: if (w_acc) begin
                w_len_nxt[15:8] = i_s_data;
                w_state_nxt     = S_ADR0;
            end
            S_ADR0: if (w_acc) begin
                w_base_lo_nxt = i_s_data;
                w_state_nxt   = S_ADR1;
            end
            S_ADR1: if (w_acc) begin
                if (w_end > MEM_BYTES) begin
                    w_state_nxt    = S_ERR;
                    w_boot_err_nxt = 1'b1;
                    w_err_code_nxt = 2'd2;
                end else if (r_len == 16'd0) begin
                    w_state_nxt = S_HDR;
                end else begin
                    w_addr_nxt   = w_base[ADDR_W-1:0];
                    w_remain_nxt = r_len;
                    w_state_nxt  = S_DATA;
                end
            end
            S_DATA: if (w_acc) begin
                w_addr_nxt   = r_addr + ADDR_W'(1);
                w_remain_nxt = r_remain - 16'd1;
                if ((w_lane == LANE_W'(WORD_BYTES - 1)) || (r_remain == 16'd1)) begin
                    w_we_nxt       = 1'b1;
                    w_mem_ch_nxt   = r_ch;
                    w_mem_addr_nxt = {r_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    w_wdata_nxt    = w_buf_upd;
                    w_mem_be_nxt   = w_be_upd;
                    w_buf_nxt      = '0;
                    w_be_nxt       = '0;
                end else begin
                    w_buf_nxt = w_buf_upd;
                    w_be_nxt  = w_be_upd;
                end
                if (r_remain == 16'd1) w_state_nxt = S_HDR;
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt      = S_DONE;
                    w_core_reset_nxt = 1'b0;
                    w_boot_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase

        w_s_ready_nxt = (w_state_nxt inside {S_HDR, S_LEN0, S_LEN1, S_ADR0, S_ADR1, S_DATA});
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_HDR;
            r_ch         <= '0;
            r_len        <= '0;
            r_base_lo    <= '0;
            r_addr       <= '0;
            r_remain     <= '0;
            r_buf        <= '0;
            r_be         <= '0;
            r_cnt        <= '0;
            o_s_ready    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_ch     <= '0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_be     <= '0;
            o_core_reset <= 1'b1;
            o_boot_done  <= 1'b0;
            o_boot_err   <= 1'b0;
            o_err_code   <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_ch         <= w_ch_nxt;
            r_len        <= w_len_nxt;
            r_base_lo    <= w_base_lo_nxt;
            r_addr       <= w_addr_nxt;
            r_remain     <= w_remain_nxt;
            r_buf        <= w_buf_nxt;
            r_be         <= w_be_nxt;
            r_cnt        <= w_cnt_nxt;
            o_s_ready    <= w_s_ready_nxt;
            o_mem_we     <= w_we_nxt;
            o_mem_ch     <= w_mem_ch_nxt;
            o_mem_addr   <= w_mem_addr_nxt;
            o_mem_wdata  <= w_wdata_nxt;
            o_mem_be     <= w_mem_be_nxt;
            o_core_reset <= w_core_reset_nxt;
            o_boot_done  <= w_boot_done_nxt;
            o_boot_err   <= w_boot_err_nxt;
            o_err_code   <= w_err_code_nxt;
        end
    end

endmodule
